sram_fifo_ctrl: RTL and testbench

//  Synchronous FIFO controller that drives the team's true dual-port SRAM macro.

---
 rtl/sram_fifo_ctrl.sv | 124 ++++++++++++
 tb/tb_sram_fifo_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_fifo_ctrl.sv
// Synchronous FIFO controller for a true dual-port SRAM (port A write, port B read).
// Optional almost_full/almost_empty outputs are enabled by defining FIFO_ALMOST_EN.
module sram_fifo_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ram_csen_n,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dina,
  output logic                  ram_wrena_n,
  output logic                  ram_rdena_n,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  output logic [DATA_WIDTH-1:0] ram_dinb,
  output logic                  ram_wrenb_n,
  output logic                  ram_rdenb_n,
  input  logic [DATA_WIDTH-1:0] ram_doutb
`ifdef FIFO_ALMOST_EN
  ,
  output logic                  almost_full,
  output logic                  almost_empty
`endif
);

  logic [ADDR_WIDTH:0] r_wr_ptr;
  logic [ADDR_WIDTH:0] r_rd_ptr;
  logic [ADDR_WIDTH:0] r_count;
  logic                r_full;
  logic                r_empty;
  logic                r_rd_valid;

  logic                w_wr_acc;
  logic                w_rd_acc;
  logic [ADDR_WIDTH:0] w_wr_ptr_nxt;
  logic [ADDR_WIDTH:0] w_rd_ptr_nxt;
  logic [ADDR_WIDTH:0] w_count_nxt;
  logic                w_full_nxt;
  logic                w_empty_nxt;

  assign w_wr_acc = push & ~r_full;
  assign w_rd_acc = pop & ~r_empty;

  // Next-state pointers, occupancy and flags; flags come from the next pointers so they register glitch-free.
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr + {{ADDR_WIDTH{1'b0}}, w_wr_acc};
    w_rd_ptr_nxt = r_rd_ptr + {{ADDR_WIDTH{1'b0}}, w_rd_acc};
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + {{ADDR_WIDTH{1'b0}}, 1'b1};
      2'b01:   w_count_nxt = r_count - {{ADDR_WIDTH{1'b0}}, 1'b1};
      default: w_count_nxt = r_count;
    endcase
    w_full_nxt  = (w_wr_ptr_nxt[ADDR_WIDTH] != w_rd_ptr_nxt[ADDR_WIDTH]) &&
                  (w_wr_ptr_nxt[ADDR_WIDTH-1:0] == w_rd_ptr_nxt[ADDR_WIDTH-1:0]);
    w_empty_nxt = (w_wr_ptr_nxt == w_rd_ptr_nxt);
  end

  // Pointer, occupancy, flag and read-valid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_rd_valid <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_count    <= w_count_nxt;
      r_full     <= w_full_nxt;
      r_empty    <= w_empty_nxt;
      r_rd_valid <= w_rd_acc;
    end
  end

`ifdef FIFO_ALMOST_EN
  localparam logic [ADDR_WIDTH:0] AF_LVL = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_LVL = (ADDR_WIDTH+1)'(AE_LEVEL);
  logic r_almost_full;
  logic r_almost_empty;

  // Watermark flags track the next occupancy so they align with count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_almost_full  <= (w_count_nxt >= AF_LVL);
      r_almost_empty <= (w_count_nxt <= AE_LVL);
    end
  end

  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
`endif

  assign rd_data     = ram_doutb;
  assign rd_valid    = r_rd_valid;
  assign full        = r_full;
  assign empty       = r_empty;
  assign count       = r_count;

  assign ram_csen_n  = rst;
  assign ram_addra   = r_wr_ptr[ADDR_WIDTH-1:0];
  assign ram_dina    = wr_data;
  assign ram_wrena_n = ~w_wr_acc;
  assign ram_rdena_n = 1'b1;
  assign ram_addrb   = r_rd_ptr[ADDR_WIDTH-1:0];
  assign ram_dinb    = {DATA_WIDTH{1'b0}};
  assign ram_wrenb_n = 1'b1;
  assign ram_rdenb_n = ~w_rd_acc;

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed self-checking bench for sram_fifo_ctrl with a behavioural dual-port SRAM.
module tb_sram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       push;
  logic [7:0] wr_data;
  logic       pop;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       ram_csen_n;
  logic [3:0] ram_addra;
  logic [7:0] ram_dina;
  logic       ram_wrena_n;
  logic       ram_rdena_n;
  logic [3:0] ram_addrb;
  logic [7:0] ram_dinb;
  logic       ram_wrenb_n;
  logic       ram_rdenb_n;
  logic [7:0] ram_doutb;
`ifdef FIFO_ALMOST_EN
  logic       almost_full;
  logic       almost_empty;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0] q_exp[$];
  logic [4:0] m_wp;
  logic [4:0] m_rp;
  int         m_cnt;
  bit         wp_wrapped;

  logic [7:0] mem [16];

  sram_fifo_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .AF_LEVEL(12), .AE_LEVEL(2)) dut (
    .clk(clk), .rst(rst), .push(push), .wr_data(wr_data), .pop(pop),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty), .count(count),
    .ram_csen_n(ram_csen_n), .ram_addra(ram_addra), .ram_dina(ram_dina),
    .ram_wrena_n(ram_wrena_n), .ram_rdena_n(ram_rdena_n), .ram_addrb(ram_addrb),
    .ram_dinb(ram_dinb), .ram_wrenb_n(ram_wrenb_n), .ram_rdenb_n(ram_rdenb_n),
    .ram_doutb(ram_doutb)
`ifdef FIFO_ALMOST_EN
    , .almost_full(almost_full), .almost_empty(almost_empty)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: write port A, registered read port B.
  always @(posedge clk) begin
    if (!ram_csen_n) begin
      if (!ram_wrena_n) mem[ram_addra] <= ram_dina;
      if (!ram_rdenb_n) ram_doutb <= mem[ram_addrb];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags();
    chk("count", 32'(count), 32'(m_cnt));
    chk("full", 32'(full), 32'(m_cnt == 16));
    chk("empty", 32'(empty), 32'(m_cnt == 0));
`ifdef FIFO_ALMOST_EN
    chk("almost_full", 32'(almost_full), 32'(m_cnt >= 12));
    chk("almost_empty", 32'(almost_empty), 32'(m_cnt <= 2));
`endif
  endtask

  task automatic model_reset();
    q_exp.delete();
    m_wp  = 5'd0;
    m_rp  = 5'd0;
    m_cnt = 0;
  endtask

  // One clock of push/pop; called at posedge+1, returns at the next posedge+1.
  task automatic cycle(input logic p, input logic [7:0] d, input logic q);
    bit         wa;
    bit         ra;
    logic [7:0] exp_d;
    exp_d   = 8'h00;
    push    = p;
    wr_data = d;
    pop     = q;
    wa = p && (m_cnt != 16);
    ra = q && (m_cnt != 0);
    #1;
    chk("wrena_n", 32'(ram_wrena_n), 32'(!wa));
    chk("addra", 32'(ram_addra), 32'(m_wp[3:0]));
    chk("rdenb_n", 32'(ram_rdenb_n), 32'(!ra));
    chk("addrb", 32'(ram_addrb), 32'(m_rp[3:0]));
    if (wa) chk("dina", 32'(ram_dina), 32'(d));
    @(posedge clk);
    if (ra) begin
      exp_d = q_exp.pop_front();
      m_rp  = m_rp + 5'd1;
    end
    if (wa) begin
      q_exp.push_back(d);
      if (m_wp == 5'd31) wp_wrapped = 1'b1;
      m_wp = m_wp + 5'd1;
    end
    m_cnt = m_cnt + int'(wa) - int'(ra);
    #1;
    chk("rd_valid", 32'(rd_valid), 32'(ra));
    if (ra) chk("rd_data", 32'(rd_data), 32'(exp_d));
    chk_flags();
    push = 1'b0;
    pop  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; wr_data = 8'h00;
    wp_wrapped = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_csen_n", 32'(ram_csen_n), 32'd1);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk_flags();
    rst = 1'b0;
    #1;
    chk("csen_n_run", 32'(ram_csen_n), 32'd0);
    chk("rdena_n_tie", 32'(ram_rdena_n), 32'd1);
    chk("wrenb_n_tie", 32'(ram_wrenb_n), 32'd1);
    chk("dinb_tie", 32'(ram_dinb), 32'd0);
    @(posedge clk); #1;

    // 1: fill, then a dropped push while full
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0);
    chk("t1_full", 32'(full), 32'd1);
    chk("t1_count", 32'(count), 32'd16);
    cycle(1'b1, 8'hAA, 1'b0);
    chk("t1_drop_count", 32'(count), 32'd16);

    // 2: drain in order
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      chk("t2_data", 32'(rd_data), 32'(i));
    end
    chk("t2_empty", 32'(empty), 32'd1);
    chk("t2_count", 32'(count), 32'd0);

    // 3: pop while empty, and simultaneous push+pop when empty takes only the push
    cycle(1'b0, 8'h00, 1'b1);
    chk("t3_rd_valid", 32'(rd_valid), 32'd0);
    chk("t3_addrb", 32'(ram_addrb), 32'd0);
    cycle(1'b1, 8'h50, 1'b1);
    chk("t3_both_empty_count", 32'(count), 32'd1);

    // 4: steady push+pop at count=5 across pointer wrap
    for (int i = 1; i < 5; i++) cycle(1'b1, 8'(8'h50 + i), 1'b0);
    wp_wrapped = 1'b0;
    for (int i = 0; i < 40; i++) cycle(1'b1, 8'(8'h60 + i), 1'b1);
    chk("t4_count", 32'(count), 32'd5);
    chk("t4_wp_wrap", 32'(wp_wrapped), 32'd1);

    // 5: reset asserted mid-cycle during a pop at count=7
    cycle(1'b1, 8'hC0, 1'b0);
    cycle(1'b1, 8'hC1, 1'b0);
    chk("t5_count7", 32'(count), 32'd7);
    pop = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_count", 32'(count), 32'd0);
    @(posedge clk); #1;
    model_reset();
    chk("t5_rd_valid", 32'(rd_valid), 32'd0);
    chk_flags();
    pop = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t5_rd_valid2", 32'(rd_valid), 32'd0);
    cycle(1'b1, 8'h3C, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    chk("t5_data", 32'(rd_data), 32'h3C);

    // 6: full/empty boundary with push+pop when full (only pop accepted)
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0);
    cycle(1'b1, 8'hEE, 1'b1);
    chk("t6_count", 32'(count), 32'd15);
    chk("t6_data", 32'(rd_data), 32'h80);
`ifdef FIFO_ALMOST_EN
    while (m_cnt > 2) cycle(1'b0, 8'h00, 1'b1);
    chk("t6_ae", 32'(almost_empty), 32'd1);
    while (m_cnt < 12) cycle(1'b1, 8'h11, 1'b0);
    chk("t6_af", 32'(almost_full), 32'd1);
`endif
    while (m_cnt > 0) cycle(1'b0, 8'h00, 1'b1);
    chk("t6_empty", 32'(empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
